// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the multi-port register file family.
package reg_file_pkg;

    localparam int RF_DATA_W_DEF = 16;
    localparam int RF_DEPTH_DEF  = 8;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: address range check, clear-aware zeroing and
// optional same-cycle write forwarding (REG_FILE_BYPASS_EN).
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W_DEF,
    parameter int DEPTH  = RF_DEPTH_DEF,
    parameter int ADDR_W = $clog2(RF_DEPTH_DEF)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      rd_en_i,
    input  logic [ADDR_W-1:0]         rd_addr_i,
    input  logic [DEPTH*DATA_W-1:0]   mem_flat_i,
    input  logic                      clr_active_i,
    input  logic [ADDR_W-1:0]         clr_addr_i,
`ifdef REG_FILE_BYPASS_EN
    input  logic                      wr_acc_i,
    input  logic [ADDR_W-1:0]         wr_addr_i,
    input  logic [DATA_W-1:0]         wr_data_i,
`endif
    output logic [DATA_W-1:0]         rd_data_o,
    output logic                      rd_valid_o,
    output logic                      rd_oor_o
);

    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              in_range;
    logic              clear_hit;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_i == ADDR_W'(i)) begin
                rd_word = mem_flat_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_range  = (rd_addr_i <= ADDR_W'(DEPTH - 1));
    // The entry being zeroed this cycle already counts as cleared for a reader.
    assign clear_hit = clr_active_i && (rd_addr_i == clr_addr_i);
    assign rd_oor_o  = rd_en_i && !in_range;

    always_comb begin
        rd_data_d = rd_word;
        if (!in_range || clear_hit) begin
            rd_data_d = '0;
        end
`ifdef REG_FILE_BYPASS_EN
        else if (wr_acc_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_d = wr_data_i;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port, two registered read ports and a
// sequenced clear. Build with REG_FILE_BYPASS_EN to forward same-cycle writes.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter  int DATA_W = RF_DATA_W_DEF,
    parameter  int DEPTH  = RF_DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              RdEn0,
    input  logic [ADDR_W-1:0] RdAddr0,
    input  logic              RdEn1,
    input  logic [ADDR_W-1:0] RdAddr1,
    input  logic              ClrReq,
    output logic [DATA_W-1:0] RdData0,
    output logic [DATA_W-1:0] RdData1,
    output logic              RdValid0,
    output logic              RdValid1,
    output logic              Busy,
    output logic              WrDrop,
    output logic              AddrErr
);

    // Reads have no backpressure: RdEn<n> in cycle t always yields RdValid<n>
    // and fresh RdData<n> in cycle t+1; RdData<n> holds while RdEn<n> is low.

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clearing;

    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [DEPTH*DATA_W-1:0] mem_flat;

    logic wr_in_range;
    logic wr_accept;
    logic wr_drop_q;
    logic addr_err_q;
    logic rd_oor0, rd_oor1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_IDLE: begin
                if (ClrReq) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            RF_CLEAR: begin
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RF_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RF_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        clearing = (state_q == RF_CLEAR);
        Busy     = clearing;
    end

    assign wr_in_range = (WrAddr <= ADDR_W'(DEPTH - 1));
    assign wr_accept   = WrEn && wr_in_range && !clearing;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clearing && (cnt_q == ADDR_W'(i))) begin
                    mem_q[i] <= '0;
                end else if (wr_accept && (WrAddr == ADDR_W'(i))) begin
                    mem_q[i] <= WrData;
                end
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign mem_flat[g*DATA_W +: DATA_W] = mem_q[g];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_drop_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            wr_drop_q  <= WrEn && (!wr_in_range || clearing);
            addr_err_q <= (WrEn && !wr_in_range) || rd_oor0 || rd_oor1;
        end
    end

    assign WrDrop  = wr_drop_q;
    assign AddrErr = addr_err_q;

    reg_file_rd_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd0 (
        .CLK          (CLK),
        .RST          (RST),
        .rd_en_i      (RdEn0),
        .rd_addr_i    (RdAddr0),
        .mem_flat_i   (mem_flat),
        .clr_active_i (clearing),
        .clr_addr_i   (cnt_q),
`ifdef REG_FILE_BYPASS_EN
        .wr_acc_i     (wr_accept),
        .wr_addr_i    (WrAddr),
        .wr_data_i    (WrData),
`endif
        .rd_data_o    (RdData0),
        .rd_valid_o   (RdValid0),
        .rd_oor_o     (rd_oor0)
    );

    reg_file_rd_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd1 (
        .CLK          (CLK),
        .RST          (RST),
        .rd_en_i      (RdEn1),
        .rd_addr_i    (RdAddr1),
        .mem_flat_i   (mem_flat),
        .clr_active_i (clearing),
        .clr_addr_i   (cnt_q),
`ifdef REG_FILE_BYPASS_EN
        .wr_acc_i     (wr_accept),
        .wr_addr_i    (WrAddr),
        .wr_data_i    (WrData),
`endif
        .rd_data_o    (RdData1),
        .rd_valid_o   (RdValid1),
        .rd_oor_o     (rd_oor1)
    );

endmodule
